etcpu_inst_loader: RTL and testbench

- Boot-time instruction loader that sits directly upstream of the CPU environment top.
- Accepts a byte stream through a valid/ready handshake and packs the bytes little-endian into 32-bit words.
- Drives the sequential instruction-memory write port: inst_mem_wr_wen, inst_mem_wr_addr, inst_mem_wr_dat.
- Holds the CPU reset (rst_n_cpu) asserted during a load and releases it a fixed number of cycles after the last write.

---
 rtl/etcpu_inst_loader.sv | 172 +++++++++++++++++
 tb/tb_etcpu_inst_loader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/etcpu_inst_loader.sv
`default_nettype none
// ============================================================================
// etcpu_inst_loader: packs a boot byte stream into 32-bit words, writes them
// to instruction memory and sequences the CPU reset around the load.
// Revision: 1.0
// ============================================================================

module etcpu_inst_loader #(
  parameter int DAT_W    = 32,
  parameter int DEPTH    = 32,
  parameter int ADD_W    = 32,
  parameter int RST_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_req,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_byte,
  input  logic             s_last,
  output logic             inst_mem_wr_wen,
  output logic [ADD_W-1:0] inst_mem_wr_addr,
  output logic [DAT_W-1:0] inst_mem_wr_dat,
  output logic             rst_n_cpu,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [ADD_W-1:0] word_cnt
);

  localparam int c_HC_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAIN = 3'd2,
    S_HOLD  = 3'd3,
    S_RUN   = 3'd4
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [1:0]         r_byte_idx, w_byte_idx_nxt;
  logic [DAT_W-1:0]   r_pack, w_pack_nxt;
  logic [ADD_W-1:0]   r_word_cnt, w_word_cnt_nxt;
  logic [c_HC_W-1:0]  r_hold_cnt, w_hold_cnt_nxt;
  logic               r_err, w_err_nxt;
  logic               r_wen, w_wen_nxt;
  logic [ADD_W-1:0]   r_addr, w_addr_nxt;
  logic [DAT_W-1:0]   r_dat, w_dat_nxt;
  logic               r_s_ready, r_busy, r_done, r_rst_n_cpu;

  logic               w_hs;
  logic               w_complete;
  logic               w_full;
  logic [DAT_W-1:0]   w_ins;

  assign w_hs       = s_valid & r_s_ready;
  assign w_complete = w_hs & ((r_byte_idx == 2'd3) | s_last);
  assign w_full     = (r_word_cnt == ADD_W'(DEPTH));
  // Current byte merged into the little-endian pack register
  assign w_ins      = r_pack | (DAT_W'(s_byte) << {r_byte_idx, 3'b000});

  always_comb begin
    w_state_nxt    = r_state;
    w_byte_idx_nxt = r_byte_idx;
    w_pack_nxt     = r_pack;
    w_word_cnt_nxt = r_word_cnt;
    w_hold_cnt_nxt = r_hold_cnt;
    w_err_nxt      = r_err;
    w_wen_nxt      = 1'b0;
    w_addr_nxt     = r_addr;
    w_dat_nxt      = r_dat;
    case (r_state)
      S_IDLE, S_RUN: begin
        if (load_req) begin
          w_state_nxt    = S_LOAD;
          w_byte_idx_nxt = 2'd0;
          w_pack_nxt     = '0;
          w_word_cnt_nxt = '0;
          w_err_nxt      = 1'b0;
        end
      end
      S_LOAD: begin
        if (w_hs) begin
          w_byte_idx_nxt = r_byte_idx + 2'd1;
          w_pack_nxt     = w_ins;
        end
        if (w_complete) begin
          w_pack_nxt = '0;
          if (s_last && (r_byte_idx != 2'd3)) begin
            w_err_nxt = 1'b1;
          end
          if (w_full) begin
            w_err_nxt      = 1'b1;
            w_state_nxt    = s_last ? S_HOLD : S_DRAIN;
            w_hold_cnt_nxt = '0;
          end else begin
            w_wen_nxt      = 1'b1;
            w_addr_nxt     = r_word_cnt;
            w_dat_nxt      = w_ins;
            w_word_cnt_nxt = r_word_cnt + ADD_W'(1);
            if (s_last) begin
              w_state_nxt    = S_HOLD;
              w_hold_cnt_nxt = '0;
            end
          end
        end
      end
      S_DRAIN: begin
        if (w_hs && s_last) begin
          w_state_nxt    = S_HOLD;
          w_hold_cnt_nxt = '0;
        end
      end
      S_HOLD: begin
        if (r_hold_cnt == c_HC_W'(RST_HOLD - 1)) begin
          w_state_nxt = S_RUN;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + c_HC_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State-derived outputs are registered from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_byte_idx  <= '0;
      r_pack      <= '0;
      r_word_cnt  <= '0;
      r_hold_cnt  <= '0;
      r_err       <= 1'b0;
      r_wen       <= 1'b0;
      r_addr      <= '0;
      r_dat       <= '0;
      r_s_ready   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rst_n_cpu <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_byte_idx  <= w_byte_idx_nxt;
      r_pack      <= w_pack_nxt;
      r_word_cnt  <= w_word_cnt_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      r_err       <= w_err_nxt;
      r_wen       <= w_wen_nxt;
      r_addr      <= w_addr_nxt;
      r_dat       <= w_dat_nxt;
      r_s_ready   <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_DRAIN);
      r_busy      <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_DRAIN) ||
                     (w_state_nxt == S_HOLD);
      r_done      <= (w_state_nxt == S_RUN);
      r_rst_n_cpu <= (w_state_nxt == S_RUN);
    end
  end

  assign s_ready          = r_s_ready;
  assign inst_mem_wr_wen  = r_wen;
  assign inst_mem_wr_addr = r_addr;
  assign inst_mem_wr_dat  = r_dat;
  assign rst_n_cpu        = r_rst_n_cpu;
  assign busy             = r_busy;
  assign done             = r_done;
  assign err              = r_err;
  assign word_cnt         = r_word_cnt;

endmodule

`default_nettype wire

// File: tb/tb_etcpu_inst_loader.sv
`default_nettype none
// ============================================================================
// tb_etcpu_inst_loader: directed bench for the boot instruction loader.
// Revision: 1.0
// ============================================================================

module tb_etcpu_inst_loader;

  localparam int DAT_W    = 32;
  localparam int DEPTH    = 32;
  localparam int ADD_W    = 32;
  localparam int RST_HOLD = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             load_req = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [7:0]       s_byte = 8'h00;
  logic             s_last = 1'b0;
  logic             inst_mem_wr_wen;
  logic [ADD_W-1:0] inst_mem_wr_addr;
  logic [DAT_W-1:0] inst_mem_wr_dat;
  logic             rst_n_cpu;
  logic             busy;
  logic             done;
  logic             err;
  logic [ADD_W-1:0] word_cnt;

  int checks   = 0;
  int failures = 0;
  int hs_waits = 0;

  logic [31:0] wq_addr[$];
  logic [31:0] wq_dat[$];
  logic [7:0]  img[0:255];

  always #5 clk = ~clk;

  etcpu_inst_loader #(
    .DAT_W(DAT_W), .DEPTH(DEPTH), .ADD_W(ADD_W), .RST_HOLD(RST_HOLD)
  ) dut (
    .clk(clk), .rst(rst), .load_req(load_req),
    .s_valid(s_valid), .s_ready(s_ready), .s_byte(s_byte), .s_last(s_last),
    .inst_mem_wr_wen(inst_mem_wr_wen), .inst_mem_wr_addr(inst_mem_wr_addr),
    .inst_mem_wr_dat(inst_mem_wr_dat), .rst_n_cpu(rst_n_cpu),
    .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
  );

  // Write-port capture
  always @(negedge clk) begin
    if (inst_mem_wr_wen === 1'b1) begin
      wq_addr.push_back(inst_mem_wr_addr);
      wq_dat.push_back(inst_mem_wr_dat);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input logic stray);
    int n = 0;
    s_valid  = 1'b1;
    s_byte   = b;
    s_last   = last;
    load_req = stray;
    while (s_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    hs_waits += n;
    tick();
    s_valid  = 1'b0;
    s_last   = 1'b0;
    load_req = 1'b0;
  endtask

  task automatic send_image(input int n, input bit bubbles);
    for (int i = 0; i < n; i++) begin
      if (bubbles) repeat ($urandom_range(0, 2)) tick();
      send_byte(img[i], (i == n - 1), (bubbles && i == 3));
    end
  endtask

  task automatic wait_run(output int n);
    n = 0;
    while (rst_n_cpu !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic set_basic_image();
    img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
    img[4] = 8'h55; img[5] = 8'h66; img[6] = 8'h77; img[7] = 8'h88;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready actual=%b expected=0", s_ready); end
    checks++; if (inst_mem_wr_wen !== 1'b0) begin failures++; $display("FAIL reset_wen actual=%b expected=0", inst_mem_wr_wen); end
    checks++; if (inst_mem_wr_addr !== 32'd0) begin failures++; $display("FAIL reset_addr actual=%h expected=0", inst_mem_wr_addr); end
    checks++; if (inst_mem_wr_dat !== 32'd0) begin failures++; $display("FAIL reset_dat actual=%h expected=0", inst_mem_wr_dat); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b expected=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done actual=%b expected=0", done); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err actual=%b expected=0", err); end
    checks++; if (word_cnt !== 32'd0) begin failures++; $display("FAIL reset_word_cnt actual=%0d expected=0", word_cnt); end
    checks++; if (rst_n_cpu !== 1'b0) begin failures++; $display("FAIL reset_rst_n_cpu actual=%b expected=0", rst_n_cpu); end
    rst = 1'b0;
    repeat (2) tick();
    checks++; if (busy !== 1'b0 || s_ready !== 1'b0) begin failures++; $display("FAIL idle_stays busy=%b s_ready=%b expected=0/0", busy, s_ready); end
  endtask

  task automatic test_basic();
    int n;
    wq_addr.delete(); wq_dat.delete();
    set_basic_image();
    hs_waits = 0;
    start_load();
    checks++; if (busy !== 1'b1 || s_ready !== 1'b1) begin failures++; $display("FAIL basic_enter_load busy=%b s_ready=%b expected=1/1", busy, s_ready); end
    send_image(8, 1'b0);
    checks++; if (hs_waits !== 0) begin failures++; $display("FAIL basic_ready_waits actual=%0d expected=0", hs_waits); end
    checks++; if (s_ready !== 1'b0 || rst_n_cpu !== 1'b0) begin failures++; $display("FAIL basic_hold s_ready=%b rst_n_cpu=%b expected=0/0", s_ready, rst_n_cpu); end
    wait_run(n);
    checks++; if (n !== RST_HOLD) begin failures++; $display("FAIL basic_release_delay actual=%0d expected=%0d", n, RST_HOLD); end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL basic_run done=%b busy=%b expected=1/0", done, busy); end
    checks++; if (wq_dat.size() !== 2) begin failures++; $display("FAIL basic_write_count actual=%0d expected=2", wq_dat.size()); end
    if (wq_dat.size() >= 2) begin
      checks++; if (wq_addr[0] !== 32'd0 || wq_dat[0] !== 32'h44332211) begin failures++; $display("FAIL basic_w0 actual=%h:%h expected=0:44332211", wq_addr[0], wq_dat[0]); end
      checks++; if (wq_addr[1] !== 32'd1 || wq_dat[1] !== 32'h88776655) begin failures++; $display("FAIL basic_w1 actual=%h:%h expected=1:88776655", wq_addr[1], wq_dat[1]); end
    end
    checks++; if (word_cnt !== 32'd2 || err !== 1'b0) begin failures++; $display("FAIL basic_status word_cnt=%0d err=%b expected=2/0", word_cnt, err); end
  endtask

  task automatic test_partial();
    int n;
    wq_addr.delete(); wq_dat.delete();
    for (int i = 0; i < 5; i++) img[i] = 8'(i + 1);
    start_load();
    send_image(5, 1'b0);
    wait_run(n);
    checks++; if (n !== RST_HOLD || done !== 1'b1) begin failures++; $display("FAIL partial_release delay=%0d done=%b expected=%0d/1", n, done, RST_HOLD); end
    checks++; if (wq_dat.size() !== 2) begin failures++; $display("FAIL partial_write_count actual=%0d expected=2", wq_dat.size()); end
    if (wq_dat.size() >= 2) begin
      checks++; if (wq_dat[0] !== 32'h04030201) begin failures++; $display("FAIL partial_w0 actual=%h expected=04030201", wq_dat[0]); end
      checks++; if (wq_addr[1] !== 32'd1 || wq_dat[1] !== 32'h00000005) begin failures++; $display("FAIL partial_w1 actual=%h:%h expected=1:00000005", wq_addr[1], wq_dat[1]); end
    end
    checks++; if (err !== 1'b1 || word_cnt !== 32'd2) begin failures++; $display("FAIL partial_status err=%b word_cnt=%0d expected=1/2", err, word_cnt); end
  endtask

  task automatic test_bubbles();
    int n;
    wq_addr.delete(); wq_dat.delete();
    set_basic_image();
    start_load();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL bubbles_err_cleared actual=%b expected=0", err); end
    send_image(8, 1'b1);
    wait_run(n);
    checks++; if (n !== RST_HOLD || done !== 1'b1) begin failures++; $display("FAIL bubbles_release delay=%0d done=%b expected=%0d/1", n, done, RST_HOLD); end
    checks++; if (wq_dat.size() !== 2) begin failures++; $display("FAIL bubbles_write_count actual=%0d expected=2", wq_dat.size()); end
    if (wq_dat.size() >= 2) begin
      checks++; if (wq_addr[0] !== 32'd0 || wq_dat[0] !== 32'h44332211) begin failures++; $display("FAIL bubbles_w0 actual=%h:%h expected=0:44332211", wq_addr[0], wq_dat[0]); end
      checks++; if (wq_addr[1] !== 32'd1 || wq_dat[1] !== 32'h88776655) begin failures++; $display("FAIL bubbles_w1 actual=%h:%h expected=1:88776655", wq_addr[1], wq_dat[1]); end
    end
    checks++; if (word_cnt !== 32'd2 || err !== 1'b0) begin failures++; $display("FAIL bubbles_status word_cnt=%0d err=%b expected=2/0", word_cnt, err); end
  endtask

  task automatic test_overflow();
    int n;
    int bad;
    logic [31:0] exp_w;
    wq_addr.delete(); wq_dat.delete();
    for (int i = 0; i < 136; i++) img[i] = 8'(i);
    hs_waits = 0;
    start_load();
    send_image(136, 1'b0);
    checks++; if (hs_waits !== 0) begin failures++; $display("FAIL overflow_ready_waits actual=%0d expected=0", hs_waits); end
    checks++; if (s_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL overflow_hold s_ready=%b busy=%b expected=0/1", s_ready, busy); end
    wait_run(n);
    checks++; if (n !== RST_HOLD || done !== 1'b1) begin failures++; $display("FAIL overflow_release delay=%0d done=%b expected=%0d/1", n, done, RST_HOLD); end
    checks++; if (wq_dat.size() !== DEPTH) begin failures++; $display("FAIL overflow_write_count actual=%0d expected=%0d", wq_dat.size(), DEPTH); end
    bad = 0;
    for (int k = 0; k < wq_dat.size() && k < DEPTH; k++) begin
      exp_w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      if (wq_addr[k] !== 32'(k) || wq_dat[k] !== exp_w) begin
        if (bad == 0) $display("FAIL overflow_word%0d actual=%h:%h expected=%h:%h", k, wq_addr[k], wq_dat[k], k, exp_w);
        bad++;
      end
    end
    checks++; if (bad !== 0) failures++;
    checks++; if (err !== 1'b1 || word_cnt !== 32'd32) begin failures++; $display("FAIL overflow_status err=%b word_cnt=%0d expected=1/32", err, word_cnt); end
  endtask

  task automatic test_reload();
    int n;
    wq_addr.delete(); wq_dat.delete();
    img[0] = 8'hAA; img[1] = 8'hBB; img[2] = 8'hCC; img[3] = 8'hDD;
    start_load();
    checks++; if (rst_n_cpu !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reload_reset rst_n_cpu=%b done=%b expected=0/0", rst_n_cpu, done); end
    checks++; if (err !== 1'b0 || word_cnt !== 32'd0) begin failures++; $display("FAIL reload_clear err=%b word_cnt=%0d expected=0/0", err, word_cnt); end
    send_image(4, 1'b0);
    wait_run(n);
    checks++; if (n !== RST_HOLD || done !== 1'b1) begin failures++; $display("FAIL reload_release delay=%0d done=%b expected=%0d/1", n, done, RST_HOLD); end
    checks++; if (wq_dat.size() !== 1) begin failures++; $display("FAIL reload_write_count actual=%0d expected=1", wq_dat.size()); end
    if (wq_dat.size() >= 1) begin
      checks++; if (wq_addr[0] !== 32'd0 || wq_dat[0] !== 32'hDDCCBBAA) begin failures++; $display("FAIL reload_w0 actual=%h:%h expected=0:DDCCBBAA", wq_addr[0], wq_dat[0]); end
    end
    checks++; if (word_cnt !== 32'd1 || err !== 1'b0) begin failures++; $display("FAIL reload_status word_cnt=%0d err=%b expected=1/0", word_cnt, err); end
  endtask

  task automatic test_reset_mid_load();
    wq_addr.delete(); wq_dat.delete();
    set_basic_image();
    start_load();
    for (int i = 0; i < 6; i++) send_byte(img[i], 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    checks++; if (inst_mem_wr_wen !== 1'b0 || word_cnt !== 32'd0) begin failures++; $display("FAIL midrst_wen_cnt wen=%b word_cnt=%0d expected=0/0", inst_mem_wr_wen, word_cnt); end
    checks++; if (rst_n_cpu !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_state rst_n_cpu=%b s_ready=%b busy=%b expected=0/0/0", rst_n_cpu, s_ready, busy); end
    rst = 1'b0;
    repeat (4) tick();
    checks++; if (wq_dat.size() !== 1) begin failures++; $display("FAIL midrst_write_count actual=%0d expected=1", wq_dat.size()); end
    if (wq_dat.size() >= 1) begin
      checks++; if (wq_addr[0] !== 32'd0 || wq_dat[0] !== 32'h44332211) begin failures++; $display("FAIL midrst_w0 actual=%h:%h expected=0:44332211", wq_addr[0], wq_dat[0]); end
    end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midrst_idle busy=%b done=%b expected=0/0", busy, done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_bubbles();
    test_overflow();
    test_reload();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
